// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Opcodes, FSM states and opcode class helpers.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_LDONE,
        S_ERR
    } state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_signed_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return is_store(op) || is_half(op) || is_word(op) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    // Rejected accesses: unknown opcode or a lane that crosses its size.
    function automatic logic is_bad(input logic [3:0] op,
                                    input logic [1:0] offset);
        return !is_legal(op) ||
               (is_half(op) && offset[0]) ||
               (is_word(op) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lane_align.sv
// Big-endian lane extraction for loads and lane merge for stores.
// Purely combinational; the FSM decides when the results are used.
module lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    input  logic [31:0] word,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign;

    // pick the addressed lane, then sign- or zero-extend it
    always_comb begin
        byte_lane = word[31:24];
        unique case (offset)
            2'd0: byte_lane = word[31:24];
            2'd1: byte_lane = word[23:16];
            2'd2: byte_lane = word[15:8];
            2'd3: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[15:0] : word[31:16];
        sign      = is_signed_load(op);
        load_data = {24'h0, byte_lane};
        unique case (1'b1)
            is_word(op): load_data = word;
            is_half(op): load_data = {{16{sign & half_lane[15]}}, half_lane};
            default:     load_data = {{24{sign & byte_lane[7]}}, byte_lane};
        endcase
    end

    // overwrite only the addressed lane of the old word
    always_comb begin
        merged = word;
        if (is_half(op)) begin
            if (offset[1]) merged[15:0]  = store_data;
            else           merged[31:16] = store_data;
        end else begin
            unique case (offset)
                2'd0: merged[31:24] = store_data[7:0];
                2'd1: merged[23:16] = store_data[7:0];
                2'd2: merged[15:8]  = store_data[7:0];
                2'd3: merged[7:0]   = store_data[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit for a word-wide data memory.
// Sub-word stores run as read-modify-write; bad accesses never touch memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit WORD_ADDRESSED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        accept;
    logic [31:0] word_address;
    logic [31:0] ext_word;
    logic [31:0] merged_word;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    assign word_address = WORD_ADDRESSED ? {2'b00, addr_q[31:2]}
                                         : {addr_q[31:2], 2'b00};

    lane_align u_lane_align (
        .offset     (addr_q[1:0]),
        .op         (op_q),
        .word       (mem_read_data),
        .store_data (data_q[15:0]),
        .load_data  (ext_word),
        .merged     (merged_word)
    );

    // state register; reset abandons any access in flight
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // capture the request so EX is free once it is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= 4'h0;
            addr_q <= 32'h0;
            data_q <= 32'h0;
        end else if (accept) begin
            op_q   <= req_op;
            addr_q <= req_address;
            data_q <= req_store_data;
        end
    end

    // sequencing: SW writes directly, sub-word stores read first
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_bad(req_op, req_address[1:0])) next_state = S_ERR;
                    else if (req_op == OP_SW)             next_state = S_WR;
                    else                                  next_state = S_RD;
                end
            end
            S_RD:    next_state = is_store(op_q) ? S_WR : S_LDONE;
            S_WR:    next_state = S_IDLE;
            S_LDONE: next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // memory strobes and completion outputs, all zero unless active
    always_comb begin
        done           = 1'b0;
        error          = 1'b0;
        load_data      = 32'h0;
        mem_address    = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = 32'h0;
        unique case (state)
            S_RD: begin
                mem_read    = 1'b1;
                mem_address = word_address;
            end
            S_WR: begin
                mem_write      = 1'b1;
                mem_address    = word_address;
                mem_write_data = (op_q == OP_SW) ? data_q : merged_word;
                done           = 1'b1;
            end
            S_LDONE: begin
                done      = 1'b1;
                load_data = ext_word;
            end
            S_ERR: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Directed table, reset abort, then a random back-to-back stream.
module tb_load_store_unit;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0011;
    localparam logic [3:0] LBU = 4'b0100, LHU = 4'b0101;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1011;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    logic [31:0] mem [0:255];
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int last_rd_cyc = 0, last_wr_cyc = 0;
    logic [31:0] last_wr_addr = 32'h0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    load_store_unit #(.WORD_ADDRESSED(1'b1)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_address    (req_address),
        .req_store_data (req_store_data),
        .done           (done),
        .error          (error),
        .load_data      (load_data),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // synchronous word memory plus strobe bookkeeping
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_address[7:0]] <= mem_write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_cyc  <= cyc;
            last_wr_addr <= mem_address;
        end
        if (mem_read) begin
            mem_read_data <= mem[mem_address[7:0]];
            rd_cnt        <= rd_cnt + 1;
            last_rd_cyc   <= cyc;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid      = 1'b1;
        req_op         = op;
        req_address    = a;
        req_store_data = d;
    endtask

    // one request; lat counts edges from accept to the done cycle
    task automatic run_req(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] d, output logic err,
                           output logic [31:0] ld, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        check("ready_wait", {31'h0, req_ready}, 32'h1);
        present(op, a, d);
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clock); #1; lat++;
        end
        if (!done) lat = -1;
        err = error;
        ld  = load_data;
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          nrd;
        int          nwr;
        logic        chk_mem;
        logic [31:0] mem_word;
    } vec_t;

    vec_t vec [17];

    // higher-level reference: byte-addressed big-endian memory
    logic [7:0] ref_bytes [0:255];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
    } exp_t;

    task automatic model_access(input req_t r, output exp_t e,
                                output int nrd, output int nwr);
        int size;
        logic ld_op, st_op, sgn;
        longint unsigned v;
        size = 0; ld_op = 0; st_op = 0; sgn = 0;
        case (r.op)
            LB:  begin size = 1; ld_op = 1; sgn = 1; end
            LBU: begin size = 1; ld_op = 1; end
            LH:  begin size = 2; ld_op = 1; sgn = 1; end
            LHU: begin size = 2; ld_op = 1; end
            LW:  begin size = 4; ld_op = 1; end
            SB:  begin size = 1; st_op = 1; end
            SH:  begin size = 2; st_op = 1; end
            SW:  begin size = 4; st_op = 1; end
            default: size = 0;
        endcase
        e.ld = 32'h0; nrd = 0; nwr = 0;
        e.err = (size == 0) || ((r.addr % size) != 0);
        if (e.err) begin
            e.lat = 1;
        end else if (ld_op) begin
            v = 0;
            for (int i = 0; i < size; i++)
                v = (v << 8) | longint'(ref_bytes[r.addr + i]);
            if (sgn && v[8 * size - 1]) v = v | (~64'd0 << (8 * size));
            e.ld = v[31:0];
            e.lat = 2; nrd = 1;
        end else begin
            for (int i = 0; i < size; i++)
                ref_bytes[r.addr + i] = 8'(r.data >> (8 * (size - 1 - i)));
            nwr = 1;
            nrd = (size < 4) ? 1 : 0;
            e.lat = (size < 4) ? 2 : 1;
        end
    endtask

    logic        t_err;
    logic [31:0] t_ld;
    int          t_lat;
    int          rd0, wr0, d0;
    req_t        rq [$];
    exp_t        eq [$];
    int          acc_q [$];

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_op = 4'h0;
        req_address = 32'h0; req_store_data = 32'h0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_ready", {31'h0, req_ready}, 32'h1);
        check("reset_flags", {28'h0, done, error, mem_read, mem_write}, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        check("reset_mem_addr", mem_address, 32'h0);
        check("reset_mem_wdata", mem_write_data, 32'h0);

        //         op   addr      data         err ld        lat rd wr chk mem
        vec[0]  = '{SW,  32'h20, 32'h11223380, 0, 32'h0,        1, 0, 1, 1, 32'h11223380};
        vec[1]  = '{SW,  32'h30, 32'hAABBCCDD, 0, 32'h0,        1, 0, 1, 1, 32'hAABBCCDD};
        vec[2]  = '{SW,  32'h50, 32'hCAFEF00D, 0, 32'h0,        1, 0, 1, 1, 32'hCAFEF00D};
        vec[3]  = '{SW,  32'h10, 32'hDEADBEEF, 0, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF};
        vec[4]  = '{LW,  32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 1, 0, 0, 32'h0};
        vec[5]  = '{LB,  32'h23, 32'h0,        0, 32'hFFFFFF80, 2, 1, 0, 0, 32'h0};
        vec[6]  = '{LBU, 32'h23, 32'h0,        0, 32'h00000080, 2, 1, 0, 0, 32'h0};
        vec[7]  = '{LH,  32'h22, 32'h0,        0, 32'h00003380, 2, 1, 0, 0, 32'h0};
        vec[8]  = '{LB,  32'h20, 32'h0,        0, 32'h00000011, 2, 1, 0, 0, 32'h0};
        vec[9]  = '{LHU, 32'h20, 32'h0,        0, 32'h00001122, 2, 1, 0, 0, 32'h0};
        vec[10] = '{SB,  32'h31, 32'h55,       0, 32'h0,        2, 1, 1, 1, 32'hAA55CCDD};
        vec[11] = '{SH,  32'h32, 32'h1234,     0, 32'h0,        2, 1, 1, 1, 32'hAA551234};
        vec[12] = '{LH,  32'h30, 32'h0,        0, 32'hFFFFAA55, 2, 1, 0, 0, 32'h0};
        vec[13] = '{LW,  32'h41, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0};
        vec[14] = '{SH,  32'h43, 32'h0,        1, 32'h0,        1, 0, 0, 0, 32'h0};
        vec[15] = '{4'b0010, 32'h40, 32'h0,    1, 32'h0,        1, 0, 0, 0, 32'h0};
        vec[16] = '{SB,  32'h33, 32'hFFFFFF7E, 0, 32'h0,        2, 1, 1, 1, 32'hAA55127E};

        foreach (vec[i]) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            run_req(vec[i].op, vec[i].addr, vec[i].data, t_err, t_ld, t_lat);
            check($sformatf("v%0d_error", i), {31'h0, t_err}, {31'h0, vec[i].err});
            check($sformatf("v%0d_load_data", i), t_ld, vec[i].ld);
            check($sformatf("v%0d_latency", i), t_lat, vec[i].lat);
            check($sformatf("v%0d_reads", i), rd_cnt - rd0, vec[i].nrd);
            check($sformatf("v%0d_writes", i), wr_cnt - wr0, vec[i].nwr);
            check($sformatf("v%0d_idle_after", i), {30'h0, req_ready, done}, 32'h2);
            if (vec[i].chk_mem) begin
                check($sformatf("v%0d_mem", i), mem[vec[i].addr[9:2]], vec[i].mem_word);
                check($sformatf("v%0d_waddr", i), last_wr_addr, {2'b00, vec[i].addr[31:2]});
            end
            if (vec[i].chk_mem && vec[i].nrd == 1)
                check($sformatf("v%0d_rmw_adjacent", i), last_wr_cyc, last_rd_cyc + 1);
        end

        // reset while the read of a read-modify-write is on the bus
        present(SB, 32'h50, 32'h99);
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("abort_in_rd", {31'h0, mem_read}, 32'h1);
        wr0 = wr_cnt; d0 = done_cnt;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_quiet", {29'h0, done, mem_write, mem_read}, 32'h0);
        repeat (3) begin @(posedge clock); #1; end
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        run_req(LW, 32'h50, 32'h0, t_err, t_ld, t_lat);
        check("abort_mem_kept", t_ld, 32'hCAFEF00D);

        // random back-to-back stream against the byte-level model
        for (int w = 0; w < 64; w++)
            rq.push_back('{SW, 32'(w * 4), $urandom});
        for (int k = 0; k < 300; k++) begin
            req_t r;
            int sel;
            r.op = 4'($urandom_range(0, 15));
            r.addr = 32'($urandom_range(0, 255));
            sel = $urandom_range(0, 3);
            if (sel == 1) r.addr = r.addr & ~32'h1;
            else if (sel >= 2) r.addr = r.addr & ~32'h3;
            r.data = $urandom;
            rq.push_back(r);
        end
        begin
            int n_req, accepted, guard, exp_rd, exp_wr;
            logic rdy;
            exp_t e;
            int nr, nw, acc;
            n_req = rq.size(); accepted = 0; guard = 0;
            exp_rd = 0; exp_wr = 0;
            rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_cnt;
            present(rq[0].op, rq[0].addr, rq[0].data);
            while ((rq.size() > 0 || eq.size() > 0) && guard < 5000) begin
                rdy = req_ready;
                @(posedge clock); #1;
                guard++;
                if (rdy && req_valid) begin
                    model_access(rq[0], e, nr, nw);
                    eq.push_back(e); acc_q.push_back(guard);
                    exp_rd += nr; exp_wr += nw;
                    accepted++;
                    void'(rq.pop_front());
                    req_valid = 1'b0;
                    if (rq.size() > 0 && $urandom_range(0, 3) != 0)
                        present(rq[0].op, rq[0].addr, rq[0].data);
                end else if (!req_valid && rq.size() > 0) begin
                    present(rq[0].op, rq[0].addr, rq[0].data);
                end
                if (done) begin
                    if (eq.size() == 0) begin
                        check("rnd_unexpected_done", 32'h1, 32'h0);
                    end else begin
                        e = eq.pop_front();
                        acc = acc_q.pop_front();
                        if ({error, load_data} !== {e.err, e.ld} ||
                            guard - acc + 1 != e.lat) begin
                            check("rnd_error", {31'h0, error}, {31'h0, e.err});
                            check("rnd_load_data", load_data, e.ld);
                            check("rnd_latency", guard - acc + 1, e.lat);
                        end else begin
                            tests_run++;
                        end
                    end
                end
            end
            req_valid = 1'b0;
            check("rnd_pending", rq.size() + eq.size(), 0);
            repeat (2) begin @(posedge clock); #1; end
            check("rnd_accepted", accepted, n_req);
            check("rnd_done_count", done_cnt - d0, n_req);
            check("rnd_read_strobes", rd_cnt - rd0, exp_rd);
            check("rnd_write_strobes", wr_cnt - wr0, exp_wr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
